// File: rtl/jtdd_vram_arb.sv
// Shares one synchronous video RAM between video fetches (even M phases) and CPU accesses (all other slots).
// Latency: video byte + vid_ok 3 clk after its pxl_cen; CPU write retires 2 clk, CPU read 3 clk after its slot's pxl_cen.
// Backpressure: cpu_wait stalls the CPU until a CPU slot has served it; video slots are never stalled or skipped.
module jtdd_vram_arb #(
    parameter int AW         = 12,
    parameter int BLANK_FREE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic [5:0]    M,
    input  logic          HBL,
    input  logic          VBL,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_wait,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_ok,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);

    // CPU side of the arbiter. RELEASE parks a served CPU until it drops cpu_cs,
    // so a request held high is never executed twice.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DATA,
        ST_RELEASE
    } cpu_st_e;

    cpu_st_e       st_q, st_d;
    logic          acc_we_q, acc_we_d;

    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [7:0]    ram_din_q, ram_din_d;
    logic [7:0]    cpu_din_q, cpu_din_d;
    logic [7:0]    vid_data_q, vid_data_d;
    logic          vid_ok_q, vid_ok_d;

    // Video read pipeline: p1 = address on the RAM this clk, p2 = RAM data valid this clk.
    logic          vid_p1_q, vid_p1_d;
    logic          vid_p2_q, vid_p2_d;

    logic          in_blank;
    logic          vid_phase;
    logic          vid_slot;
    logic          cpu_slot;
    logic          cpu_go;

    // Slot decode: even phases belong to video unless blanking frees them for the CPU.
    always_comb begin
        in_blank  = (BLANK_FREE != 0) && (HBL || VBL);
        vid_phase = M[0] | M[2] | M[4];
        vid_slot  = pxl_cen && vid_phase && !in_blank;
        cpu_slot  = pxl_cen && !(vid_phase && !in_blank);
        cpu_go    = (st_q == ST_WAIT) && cpu_cs && cpu_slot;
    end

    // CPU FSM next state; a dropped cpu_cs only aborts before the RAM has been touched.
    always_comb begin
        st_d     = st_q;
        acc_we_d = acc_we_q;
        case (st_q)
            ST_IDLE: begin
                if (cpu_cs) begin
                    st_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cpu_cs) begin
                    st_d = ST_IDLE;
                end else if (cpu_slot) begin
                    st_d     = ST_ACCESS;
                    acc_we_d = cpu_we;
                end
            end
            ST_ACCESS: begin
                if (!acc_we_q) begin
                    st_d = ST_DATA;
                end else if (cpu_cs) begin
                    st_d = ST_RELEASE;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                st_d = cpu_cs ? ST_RELEASE : ST_IDLE;
            end
            ST_RELEASE: begin
                if (!cpu_cs) begin
                    st_d = ST_IDLE;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // RAM port, read-data capture and video strobe; the write strobe defaults low every clk.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_we_d   = 1'b0;
        ram_din_d  = ram_din_q;
        cpu_din_d  = cpu_din_q;
        vid_data_d = vid_data_q;
        vid_ok_d   = 1'b0;
        vid_p1_d   = vid_slot;
        vid_p2_d   = vid_p1_q;

        if (vid_slot) begin
            ram_addr_d = vid_addr;
        end else if (cpu_go) begin
            ram_addr_d = cpu_addr;
            ram_we_d   = cpu_we;
            if (cpu_we) begin
                ram_din_d = cpu_dout;
            end
        end

        if (vid_p2_q) begin
            vid_data_d = ram_dout;
            vid_ok_d   = 1'b1;
        end

        if (st_q == ST_DATA) begin
            cpu_din_d = ram_dout;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q     <= ST_IDLE;
            acc_we_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            acc_we_q <= acc_we_d;
        end
    end

    // Datapath registers; reset also flushes any in-flight video fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= 8'h00;
            cpu_din_q  <= 8'h00;
            vid_data_q <= 8'h00;
            vid_ok_q   <= 1'b0;
            vid_p1_q   <= 1'b0;
            vid_p2_q   <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_din_q  <= ram_din_d;
            cpu_din_q  <= cpu_din_d;
            vid_data_q <= vid_data_d;
            vid_ok_q   <= vid_ok_d;
            vid_p1_q   <= vid_p1_d;
            vid_p2_q   <= vid_p2_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_we   = ram_we_q;
    assign ram_din  = ram_din_q;
    assign cpu_din  = cpu_din_q;
    assign vid_data = vid_data_q;
    assign vid_ok   = vid_ok_q;
    assign cpu_wait = cpu_cs && (st_q != ST_RELEASE);

`ifndef SYNTHESIS
    // The RAM may only be written while the CPU FSM sits in ACCESS.
    a_we_in_access: assert property (@(posedge clk) disable iff (!rst) ram_we_q |-> (st_q == ST_ACCESS));
`endif

endmodule

// File: tb/tb_jtdd_vram_arb.sv
module tb_jtdd_vram_arb;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          pxl_cen;
    logic [5:0]    M;
    logic          HBL, VBL;
    logic          cpu_cs, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic [7:0]    cpu_din;
    logic          cpu_wait;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_ok;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] vid_exp_q[$];
    logic [7:0] cpu_exp_q[$];

    always #5 clk = ~clk;

    jtdd_vram_arb #(.AW(AW), .BLANK_FREE(1)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .M(M), .HBL(HBL), .VBL(VBL),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_wait(cpu_wait), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_ok(vid_ok), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Initial RAM contents: a few fixed bytes, a simple pattern elsewhere.
    function automatic logic [7:0] init_val(input int a);
        case (a)
            'h123:   return 8'h5A;
            'h2AA:   return 8'h3C;
            'h0A0:   return 8'hC3;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    // Synchronous RAM model, 1-clk read latency, loaded on the first edge.
    logic [7:0] mem [0:(1<<AW)-1];
    logic       mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise pxl_cen for one clk; returns at the negedge of cycle N+1.
    task automatic fire_cen(input logic [5:0] m, input logic hbl, input logic vbl);
        M = m; HBL = hbl; VBL = vbl; pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0; M = 6'b0; HBL = 1'b0; VBL = 1'b0;
    endtask

    task automatic test_reset;
        logic seen;
        rst = 1'b0; cpu_cs = 1'b0;
        tick(3);
        n_total++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", ram_we); else n_pass++;
        n_total++; if (ram_addr !== 12'h000) $display("FAIL rst_ram_addr: got %h want 000", ram_addr); else n_pass++;
        n_total++; if (ram_din !== 8'h00) $display("FAIL rst_ram_din: got %h want 00", ram_din); else n_pass++;
        n_total++; if (cpu_din !== 8'h00) $display("FAIL rst_cpu_din: got %h want 00", cpu_din); else n_pass++;
        n_total++; if (vid_data !== 8'h00) $display("FAIL rst_vid_data: got %h want 00", vid_data); else n_pass++;
        n_total++; if (vid_ok !== 1'b0) $display("FAIL rst_vid_ok: got %b want 0", vid_ok); else n_pass++;
        n_total++; if (cpu_wait !== 1'b0) $display("FAIL rst_cpu_wait_idle: got %b want 0", cpu_wait); else n_pass++;
        // pxl_cen on a video phase while held in reset must do nothing
        cpu_cs = 1'b1; vid_addr = 12'h123;
        fire_cen(6'b000001, 1'b0, 1'b0);
        n_total++; if (cpu_wait !== 1'b1) $display("FAIL rst_cpu_wait_cs: got %b want 1", cpu_wait); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (vid_ok || ram_we) seen = 1'b1;
            @(negedge clk);
        end
        n_total++; if (seen !== 1'b0) $display("FAIL rst_cen_ignored: activity %b want 0", seen); else n_pass++;
        cpu_cs = 1'b0; rst = 1'b1;
        tick(2);
    endtask

    task automatic test_video;
        logic [5:0]    m_tab [3];
        logic [AW-1:0] a_tab [3];
        logic [7:0]    exp;
        int lat;
        m_tab = '{6'b000001, 6'b000100, 6'b010000};
        a_tab = '{12'h123, 12'h300, 12'h301};
        for (int i = 0; i < 3; i++) begin
            vid_addr = a_tab[i];
            vid_exp_q.push_back(init_val(int'(a_tab[i])));
            fire_cen(m_tab[i], 1'b0, 1'b0);
            n_total++; if (ram_addr !== a_tab[i]) $display("FAIL vid_ram_addr[%0d]: got %h want %h", i, ram_addr, a_tab[i]); else n_pass++;
            n_total++; if (ram_we !== 1'b0) $display("FAIL vid_ram_we[%0d]: got %b want 0", i, ram_we); else n_pass++;
            lat = 1;
            while (!vid_ok && lat < 8) begin @(negedge clk); lat++; end
            n_total++; if (lat !== 3) $display("FAIL vid_latency[%0d]: got %0d want 3", i, lat); else n_pass++;
            exp = vid_exp_q.pop_front();
            n_total++; if (vid_data !== exp) $display("FAIL vid_data[%0d]: got %h want %h", i, vid_data, exp); else n_pass++;
            @(negedge clk);
            n_total++; if (vid_ok !== 1'b0) $display("FAIL vid_ok_strobe[%0d]: got %b want 0", i, vid_ok); else n_pass++;
            tick(1);
        end
    endtask

    task automatic test_cpu_write;
        cpu_we = 1'b1; cpu_addr = 12'h040; cpu_dout = 8'hA5; cpu_cs = 1'b1;
        tick(2);
        n_total++; if (cpu_wait !== 1'b1) $display("FAIL wr_wait_pending: got %b want 1", cpu_wait); else n_pass++;
        fire_cen(6'b000000, 1'b0, 1'b0);
        n_total++; if (ram_we !== 1'b1) $display("FAIL wr_ram_we: got %b want 1", ram_we); else n_pass++;
        n_total++; if (ram_addr !== 12'h040) $display("FAIL wr_ram_addr: got %h want 040", ram_addr); else n_pass++;
        n_total++; if (ram_din !== 8'hA5) $display("FAIL wr_ram_din: got %h want a5", ram_din); else n_pass++;
        n_total++; if (cpu_wait !== 1'b1) $display("FAIL wr_wait_n1: got %b want 1", cpu_wait); else n_pass++;
        tick(1);
        n_total++; if (ram_we !== 1'b0) $display("FAIL wr_we_one_clk: got %b want 0", ram_we); else n_pass++;
        n_total++; if (cpu_wait !== 1'b0) $display("FAIL wr_wait_n2: got %b want 0", cpu_wait); else n_pass++;
        n_total++; if (mem[12'h040] !== 8'hA5) $display("FAIL wr_mem: got %h want a5", mem[12'h040]); else n_pass++;
        // still selected after being served: a later CPU slot must not repeat the write
        tick(2);
        fire_cen(6'b000010, 1'b0, 1'b0);
        n_total++; if (ram_we !== 1'b0) $display("FAIL wr_release_no_repeat: got %b want 0", ram_we); else n_pass++;
        cpu_cs = 1'b0;
        tick(3);
    endtask

    task automatic test_conflict;
        logic [5:0] m_tab [3];
        logic [7:0] exp;
        int lat;
        m_tab = '{6'b000001, 6'b000100, 6'b010000};
        cpu_we = 1'b0; cpu_addr = 12'h2AA; cpu_cs = 1'b1; vid_addr = 12'h111;
        cpu_exp_q.push_back(8'h3C);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            vid_exp_q.push_back(init_val('h111));
            fire_cen(m_tab[i], 1'b0, 1'b0);
            n_total++; if (ram_addr !== 12'h111) $display("FAIL cf_vid_wins_addr[%0d]: got %h want 111", i, ram_addr); else n_pass++;
            n_total++; if (cpu_wait !== 1'b1) $display("FAIL cf_cpu_waits[%0d]: got %b want 1", i, cpu_wait); else n_pass++;
            lat = 1;
            while (!vid_ok && lat < 8) begin @(negedge clk); lat++; end
            exp = vid_exp_q.pop_front();
            n_total++; if (lat !== 3 || vid_data !== exp) $display("FAIL cf_vid_data[%0d]: got %h at %0d want %h at 3", i, vid_data, lat, exp); else n_pass++;
            tick(1);
        end
        fire_cen(6'b001000, 1'b0, 1'b0);
        n_total++; if (ram_addr !== 12'h2AA) $display("FAIL cf_cpu_addr: got %h want 2aa", ram_addr); else n_pass++;
        n_total++; if (ram_we !== 1'b0) $display("FAIL cf_cpu_read_we: got %b want 0", ram_we); else n_pass++;
        tick(1);
        n_total++; if (cpu_wait !== 1'b1) $display("FAIL cf_wait_n2: got %b want 1", cpu_wait); else n_pass++;
        tick(1);
        exp = cpu_exp_q.pop_front();
        n_total++; if (cpu_wait !== 1'b0) $display("FAIL cf_wait_n3: got %b want 0", cpu_wait); else n_pass++;
        n_total++; if (cpu_din !== exp) $display("FAIL cf_cpu_din: got %h want %h", cpu_din, exp); else n_pass++;
        cpu_cs = 1'b0;
        tick(3);
    endtask

    task automatic test_blanking;
        logic [7:0] exp;
        logic vseen;
        cpu_we = 1'b0; cpu_addr = 12'h0A0; cpu_cs = 1'b1; vid_addr = 12'h123;
        cpu_exp_q.push_back(8'hC3);
        tick(2);
        fire_cen(6'b000100, 1'b0, 1'b1);
        n_total++; if (ram_addr !== 12'h0A0) $display("FAIL bl_cpu_addr: got %h want 0a0", ram_addr); else n_pass++;
        vseen = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (vid_ok) vseen = 1'b1;
            if (k == 3) begin
                exp = cpu_exp_q.pop_front();
                n_total++; if (cpu_wait !== 1'b0 || cpu_din !== exp) $display("FAIL bl_cpu_served: wait %b din %h want 0 %h", cpu_wait, cpu_din, exp); else n_pass++;
            end
            @(negedge clk);
        end
        n_total++; if (vseen !== 1'b0) $display("FAIL bl_no_vid_ok: got %b want 0", vseen); else n_pass++;
        cpu_cs = 1'b0;
        tick(2);
    endtask

    task automatic test_cs_drop_access;
        logic [7:0] exp;
        cpu_we = 1'b0; cpu_addr = 12'h345; cpu_cs = 1'b1;
        cpu_exp_q.push_back(init_val('h345));
        tick(2);
        fire_cen(6'b000010, 1'b0, 1'b0);
        cpu_cs = 1'b0;
        tick(2);
        exp = cpu_exp_q.pop_front();
        n_total++; if (cpu_din !== exp) $display("FAIL drop_access_din: got %h want %h", cpu_din, exp); else n_pass++;
        tick(2);
    endtask

    task automatic test_abort;
        logic seen_we, moved;
        cpu_we = 1'b1; cpu_addr = 12'h0FF; cpu_dout = 8'hEE; cpu_cs = 1'b1;
        tick(2);
        cpu_cs = 1'b0;
        fire_cen(6'b000010, 1'b0, 1'b0);
        seen_we = 1'b0; moved = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (ram_we) seen_we = 1'b1;
            if (ram_addr !== 12'h345) moved = 1'b1;
            @(negedge clk);
        end
        n_total++; if (seen_we !== 1'b0) $display("FAIL abort_no_we: got %b want 0", seen_we); else n_pass++;
        n_total++; if (moved !== 1'b0) $display("FAIL abort_addr_held: got %h want 345", ram_addr); else n_pass++;
        n_total++; if (mem[12'h0FF] !== init_val('hFF)) $display("FAIL abort_mem: got %h want %h", mem[12'h0FF], init_val('hFF)); else n_pass++;
        // a fresh request must go through from IDLE
        cpu_cs = 1'b1;
        tick(2);
        fire_cen(6'b000000, 1'b0, 1'b0);
        n_total++; if (ram_we !== 1'b1 || ram_addr !== 12'h0FF) $display("FAIL abort_then_write: we %b addr %h want 1 0ff", ram_we, ram_addr); else n_pass++;
        tick(1);
        n_total++; if (mem[12'h0FF] !== 8'hEE) $display("FAIL abort_then_mem: got %h want ee", mem[12'h0FF]); else n_pass++;
        cpu_cs = 1'b0;
        tick(2);
    endtask

    task automatic test_back_to_back;
        logic [5:0] m_tab [4];
        logic [7:0] exp;
        int got;
        m_tab = '{6'b000001, 6'b000100, 6'b010000, 6'b000001};
        got = 0;
        for (int i = 0; i < 4; i++) begin
            vid_addr = 12'h400 + 12'(i);
            vid_exp_q.push_back(init_val('h400 + i));
            M = m_tab[i]; pxl_cen = 1'b1;
            @(negedge clk);
            pxl_cen = 1'b0; M = 6'b0;
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                if (vid_ok) begin
                    got++;
                    exp = (vid_exp_q.size() > 0) ? vid_exp_q.pop_front() : 8'hXX;
                    n_total++; if (vid_data !== exp) $display("FAIL b2b_data[%0d]: got %h want %h", i, vid_data, exp); else n_pass++;
                end
            end
            @(negedge clk);
        end
        n_total++; if (got !== 4 || vid_exp_q.size() !== 0) $display("FAIL b2b_count: got %0d left %0d want 4 0", got, vid_exp_q.size()); else n_pass++;
        tick(2);
    endtask

    task automatic test_reset_mid_access;
        cpu_we = 1'b1; cpu_addr = 12'h055; cpu_dout = 8'h99; cpu_cs = 1'b1;
        tick(2);
        fire_cen(6'b000000, 1'b0, 1'b0);
        n_total++; if (ram_we !== 1'b1) $display("FAIL rma_we_before: got %b want 1", ram_we); else n_pass++;
        rst = 1'b0;
        tick(1);
        n_total++; if (ram_we !== 1'b0) $display("FAIL rma_we: got %b want 0", ram_we); else n_pass++;
        n_total++; if (ram_addr !== 12'h000 || ram_din !== 8'h00) $display("FAIL rma_ram_port: addr %h din %h want 000 00", ram_addr, ram_din); else n_pass++;
        n_total++; if (cpu_din !== 8'h00 || vid_data !== 8'h00 || vid_ok !== 1'b0) $display("FAIL rma_outputs: din %h vd %h ok %b want 00 00 0", cpu_din, vid_data, vid_ok); else n_pass++;
        n_total++; if (cpu_wait !== 1'b1) $display("FAIL rma_cpu_wait: got %b want 1", cpu_wait); else n_pass++;
        cpu_cs = 1'b0; rst = 1'b1;
        tick(3);
        // reset landing while a video fetch is in flight cancels its vid_ok
        vid_addr = 12'h123;
        fire_cen(6'b000001, 1'b0, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(1);
        n_total++; if (vid_ok !== 1'b0) $display("FAIL rst_cancel_vid_ok: got %b want 0", vid_ok); else n_pass++;
        rst = 1'b1;
        tick(1);
        n_total++; if (vid_ok !== 1'b0) $display("FAIL rst_cancel_vid_ok2: got %b want 0", vid_ok); else n_pass++;
        tick(2);
    endtask

    initial begin
        rst = 1'b0; pxl_cen = 1'b0; M = 6'b0; HBL = 1'b0; VBL = 1'b0;
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_dout = 8'h00; vid_addr = '0;
        test_reset();
        test_video();
        test_cpu_write();
        test_conflict();
        test_blanking();
        test_cs_drop_access();
        test_abort();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jtdd_vram_arb.md
JTDD_VRAM_ARB -- requirements
Module: jtdd_vram_arb

Interface
REQ-001 Parameter AW, default 12: address width of the shared video RAM.
REQ-002 Parameter BLANK_FREE, default 1: when 1, every slot during HBL or VBL goes to the CPU.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 pxl_cen  input  1  pixel clock enable; one slot decision per pulse; pulses at least 4 clk apart.
REQ-006 M  input  6  bus phase, one-hot or all-zero; sampled on pxl_cen.
REQ-007 HBL, VBL  input  1 each  horizontal/vertical blanking flags from the video timing block.
REQ-008 cpu_cs  input  1  CPU request; held until cpu_wait is low.
REQ-009 cpu_we  input  1  1 = write, 0 = read; stable while cpu_cs is high.
REQ-010 cpu_addr  input  AW  CPU address.
REQ-011 cpu_dout  input  8  CPU write data.
REQ-012 cpu_din  output  8  CPU read data, registered.
REQ-013 cpu_wait  output  1  CPU stall; combinational: cpu_cs AND state != RELEASE.
REQ-014 vid_addr  input  AW  video fetch address.
REQ-015 vid_data  output  8  fetched video byte, registered.
REQ-016 vid_ok  output  1  one-clk strobe marking a new vid_data.
REQ-017 ram_addr  output  AW  RAM address, registered.
REQ-018 ram_we  output  1  RAM write strobe, registered.
REQ-019 ram_din  output  8  RAM write data, registered.
REQ-020 ram_dout  input  8  RAM read data; the RAM is synchronous with 1-clk read latency.

Function
REQ-021 Slot type is decided on each pxl_cen cycle (N).
REQ-022 The slot is a video slot when M[0], M[2] or M[4] is set and !(BLANK_FREE && (HBL || VBL)); otherwise it is a CPU slot.
REQ-023 Video slot: ram_addr = vid_addr and ram_we = 0 from cycle N+1; vid_data = ram_dout latched at the end of N+2; vid_ok is high during N+3 only.
REQ-024 A video slot is always executed; it does not depend on any request signal.
REQ-025 CPU state machine states: IDLE, WAIT, ACCESS, DATA, RELEASE.
REQ-026 IDLE -> WAIT on the clk after cpu_cs is seen high.
REQ-027 WAIT -> ACCESS on a CPU-slot pxl_cen; ram_addr = cpu_addr from N+1.
REQ-028 Write in ACCESS: ram_we = 1 and ram_din = cpu_dout for exactly one clk (N+1), then -> RELEASE; cpu_wait is low from N+2.
REQ-029 Read in ACCESS: ram_we = 0; ACCESS -> DATA; cpu_din = ram_dout latched at the end of N+2; -> RELEASE; cpu_wait is low from N+3.
REQ-030 RELEASE -> IDLE when cpu_cs is low; while cpu_cs stays high, no further access is made.
REQ-031 Simultaneous video slot and pending CPU request: video wins; the CPU stays in WAIT with cpu_wait high.
REQ-032 cpu_cs drops in WAIT: -> IDLE with no RAM access.
REQ-033 cpu_cs drops in ACCESS or DATA: the access completes, then -> IDLE.
REQ-034 ram_we is never high in a video slot or outside ACCESS.
REQ-035 Address and data widths pass through unchanged; there is no arithmetic on addresses.
REQ-036 The all-zero M phase, and odd-bit phases, are CPU slots.

Reset
REQ-037 While rst = 0 at a clk edge: state = IDLE; ram_we = 0; ram_addr = 0; ram_din = 0; cpu_din = 0; vid_data = 0; vid_ok = 0.
REQ-038 Reset asserted mid-access aborts the access; ram_we is 0 from the clk after the reset edge, and any pending vid_ok is cancelled.
REQ-039 pxl_cen is ignored while rst = 0.

Verification
REQ-040 Video slot: M = 6'b000001, HBL = 0, vid_addr = 0x123, RAM[0x123] = 0x5A -> vid_ok high 3 clk after the cen, with vid_data = 0x5A.
REQ-041 CPU write: cpu_cs = 1, cpu_we = 1, cpu_addr = 0x040, cpu_dout = 0xA5, first CPU slot -> ram_we high for one clk at 0x040/0xA5; cpu_wait low 2 clk after the cen; RAM[0x040] = 0xA5.
REQ-042 Conflict: CPU read pending while video slots come from M[0], M[2], M[4] with HBL = 0 -> no CPU access on those cens; the CPU read executes on the next CPU slot, and cpu_din = RAM data with cpu_wait low 3 clk after that cen.
REQ-043 Blanking: BLANK_FREE = 1, VBL = 1, M = 6'b000100, CPU read pending -> the CPU is served and vid_ok stays low.
REQ-044 Abort: cpu_cs dropped while in WAIT -> no ram_we and no address change for the CPU; state returns to IDLE.
REQ-045 Reset during a write's ACCESS cycle -> ram_we = 0 from the next clk; all outputs take their reset values; cpu_wait = cpu_cs.
